// File: rtl/sensor_frame_parser.sv
// Parses ASCII sensor frames ('R', 1..MAX_DIGITS digits, CR) from a UART byte
// stream and publishes the last good reading as packed BCD and binary.
module sensor_frame_parser #(
    parameter int unsigned MAX_DIGITS     = 4,
    parameter int unsigned BIN_W          = 14,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  START_CHAR     = 8'h52,
    parameter logic [7:0]  END_CHAR       = 8'h0D
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_data_rdy,
    output logic [4*MAX_DIGITS-1:0] value_bcd,
    output logic [BIN_W-1:0]        value_bin,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic [1:0]              err_code,
    output logic [7:0]              frame_count
);

    localparam int unsigned BCD_W = 4 * MAX_DIGITS;
    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        DIGITS = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [BCD_W-1:0]  bcd_acc, bcd_acc_nxt;
    logic [BIN_W-1:0]  bin_acc, bin_acc_nxt;
    logic [CNT_W-1:0]  digit_cnt, digit_cnt_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic [BCD_W-1:0]  value_bcd_nxt;
    logic [BIN_W-1:0]  value_bin_nxt;
    logic              frame_valid_nxt;
    logic              frame_err_nxt;
    logic [1:0]        err_code_nxt;
    logic [7:0]        frame_count_nxt;

    logic              is_digit;
    logic [3:0]        digit;

    // ASCII '0'..'9' carry their value in the low nibble
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign digit    = rx_data[3:0];

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bcd_acc     <= '0;
            bin_acc     <= '0;
            digit_cnt   <= '0;
            timer       <= '0;
            value_bcd   <= '0;
            value_bin   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'b00;
            frame_count <= 8'd0;
        end else begin
            state       <= state_nxt;
            bcd_acc     <= bcd_acc_nxt;
            bin_acc     <= bin_acc_nxt;
            digit_cnt   <= digit_cnt_nxt;
            timer       <= timer_nxt;
            value_bcd   <= value_bcd_nxt;
            value_bin   <= value_bin_nxt;
            frame_valid <= frame_valid_nxt;
            frame_err   <= frame_err_nxt;
            err_code    <= err_code_nxt;
            frame_count <= frame_count_nxt;
        end
    end

    // Next-state, accumulator and output logic
    always_comb begin
        state_nxt       = state;
        bcd_acc_nxt     = bcd_acc;
        bin_acc_nxt     = bin_acc;
        digit_cnt_nxt   = digit_cnt;
        timer_nxt       = timer;
        value_bcd_nxt   = value_bcd;
        value_bin_nxt   = value_bin;
        frame_valid_nxt = 1'b0;
        frame_err_nxt   = 1'b0;
        err_code_nxt    = err_code;
        frame_count_nxt = frame_count;

        case (state)
            IDLE: begin
                if (rx_data_rdy && (rx_data == START_CHAR)) begin
                    state_nxt     = DIGITS;
                    bcd_acc_nxt   = '0;
                    bin_acc_nxt   = '0;
                    digit_cnt_nxt = '0;
                    timer_nxt     = '0;
                end
            end

            DIGITS: begin
                if (rx_data_rdy) begin
                    timer_nxt = '0;
                    if (is_digit) begin
                        if (digit_cnt < CNT_W'(MAX_DIGITS)) begin
                            bcd_acc_nxt   = (bcd_acc << 4) | BCD_W'(digit);
                            bin_acc_nxt   = (bin_acc << 3) + (bin_acc << 1) + BIN_W'(digit);
                            digit_cnt_nxt = digit_cnt + CNT_W'(1);
                        end else begin
                            state_nxt     = IDLE;
                            frame_err_nxt = 1'b1;
                            err_code_nxt  = ERR_LEN;
                        end
                    end else if (rx_data == END_CHAR) begin
                        state_nxt = IDLE;
                        if (digit_cnt != '0) begin
                            value_bcd_nxt   = bcd_acc;
                            value_bin_nxt   = bin_acc;
                            frame_valid_nxt = 1'b1;
                            frame_count_nxt = frame_count + 8'd1;
                        end else begin
                            frame_err_nxt = 1'b1;
                            err_code_nxt  = ERR_LEN;
                        end
                    end else if (rx_data == START_CHAR) begin
                        // Truncated frame: flag it and resync onto the new one
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = ERR_LEN;
                        bcd_acc_nxt   = '0;
                        bin_acc_nxt   = '0;
                        digit_cnt_nxt = '0;
                    end else begin
                        state_nxt     = IDLE;
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = ERR_ILLEGAL;
                    end
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                    if (timer == TMR_W'(TIMEOUT_CYCLES - 2)) begin
                        state_nxt     = IDLE;
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = ERR_TIMEOUT;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sensor_frame_parser.sv
// Randomized and directed bench for sensor_frame_parser against a queue-based
// frame model that predicts every output on every clock.
module tb_sensor_frame_parser;

    localparam int unsigned MAXD  = 4;
    localparam int unsigned BIN_W = 14;
    localparam int          TO    = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_data_rdy = 1'b0;
    logic [4*MAXD-1:0] value_bcd;
    logic [BIN_W-1:0]  value_bin;
    logic              frame_valid;
    logic              frame_err;
    logic [1:0]        err_code;
    logic [7:0]        frame_count;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: frame contents kept as a queue of digit values
    bit m_in;
    int m_q[$];
    int m_gap;
    int e_bin, e_bcd, e_code, e_cnt;
    bit e_valid, e_err;

    sensor_frame_parser #(
        .MAX_DIGITS(MAXD),
        .BIN_W(BIN_W),
        .TIMEOUT_CYCLES(TO),
        .START_CHAR(8'h52),
        .END_CHAR(8'h0D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_data_rdy(rx_data_rdy),
        .value_bcd(value_bcd),
        .value_bin(value_bin),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .err_code(err_code),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic m_fail(input int code);
        e_err  = 1'b1;
        e_code = code;
        m_in   = 1'b0;
    endtask

    task automatic model_step(input logic rst, input logic rdy, input logic [7:0] d);
        int v;
        int b;
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (!rst) begin
            m_in = 1'b0; m_q.delete(); m_gap = 0;
            e_bin = 0; e_bcd = 0; e_code = 0; e_cnt = 0;
            return;
        end
        if (!m_in) begin
            if (rdy && d == 8'h52) begin
                m_in = 1'b1; m_q.delete(); m_gap = 0;
            end
        end else if (rdy) begin
            m_gap = 0;
            if (d >= 8'h30 && d <= 8'h39) begin
                if (m_q.size() < MAXD) m_q.push_back(int'(d) - 48);
                else m_fail(1);
            end else if (d == 8'h0D) begin
                if (m_q.size() == 0) m_fail(1);
                else begin
                    v = 0; b = 0;
                    foreach (m_q[i]) begin
                        v = v * 10 + m_q[i];
                        b = b * 16 + m_q[i];
                    end
                    e_bin = v; e_bcd = b; e_valid = 1'b1;
                    e_cnt = (e_cnt + 1) % 256;
                    m_in = 1'b0;
                end
            end else if (d == 8'h52) begin
                m_fail(1);
                m_in = 1'b1; m_q.delete();
            end else begin
                m_fail(2);
            end
        end else begin
            m_gap++;
            if (m_gap == TO - 1) m_fail(3);
        end
    endtask

    task automatic compare_all();
        check("frame_valid", 32'(frame_valid), 32'(e_valid));
        check("frame_err", 32'(frame_err), 32'(e_err));
        check("err_code", 32'(err_code), 32'(e_code));
        check("frame_count", 32'(frame_count), 32'(e_cnt));
        check("value_bin", 32'(value_bin), 32'(e_bin));
        check("value_bcd", 32'(value_bcd), 32'(e_bcd));
        check("valid_err_excl", 32'(frame_valid & frame_err), 32'd0);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after
    task automatic cycle(input logic rdy, input logic [7:0] d);
        rx_data_rdy = rdy;
        rx_data     = d;
        @(posedge clk);
        model_step(rst_n, rdy, d);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        cycle(1'b1, b);
        idle(gap);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    endtask

    task automatic frame(input string body, input int gap);
        send_str(body, gap);
        send_byte(8'h0D, gap);
    endtask

    initial begin
        rst_n = 1'b0;
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        check("rst_bcd", 32'(value_bcd), 32'd0);
        check("rst_bin", 32'(value_bin), 32'd0);
        check("rst_cnt", 32'(frame_count), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;

        // Good frame at 10-cycle spacing, valid exactly one cycle after CR
        send_str("R123", 9);
        cycle(1'b1, 8'h0D);
        check("lat_valid", 32'(frame_valid), 32'd1);
        check("bcd_123", 32'(value_bcd), 32'h0123);
        check("bin_123", 32'(value_bin), 32'd123);
        check("cnt_1", 32'(frame_count), 32'd1);
        idle(9);

        frame("R9999", 1);
        check("bcd_9999", 32'(value_bcd), 32'h9999);
        check("bin_9999", 32'(value_bin), 32'd9999);

        send_str("R1234", 1);
        cycle(1'b1, "5");
        check("len_err", 32'(frame_err), 32'd1);
        check("len_code", 32'(err_code), 32'd1);
        check("len_keep_bin", 32'(value_bin), 32'd9999);
        idle(2);
        cycle(1'b1, 8'h0D);
        check("cr_in_idle", 32'(frame_err | frame_valid), 32'd0);

        send_str("R1", 1);
        cycle(1'b1, "A");
        check("ill_err", 32'(frame_err), 32'd1);
        check("ill_code", 32'(err_code), 32'd2);
        idle(2);
        send_byte(8'h0D, 1);

        send_str("R", 1);
        cycle(1'b1, 8'h0D);
        check("empty_err", 32'(frame_err), 32'd1);
        check("empty_code", 32'(err_code), 32'd1);
        check("empty_cnt", 32'(frame_count), 32'd2);
        check("empty_bin", 32'(value_bin), 32'd9999);
        idle(2);

        // Resync onto a second start byte
        send_str("R45", 1);
        cycle(1'b1, "R");
        check("resync_err", 32'(frame_err), 32'd1);
        check("resync_code", 32'(err_code), 32'd1);
        idle(1);
        send_str("67", 1);
        cycle(1'b1, 8'h0D);
        check("resync_valid", 32'(frame_valid), 32'd1);
        check("resync_bin", 32'(value_bin), 32'd67);
        check("resync_bcd", 32'(value_bcd), 32'h0067);
        idle(2);

        // Timeout fires 99 clocks after the last byte
        send_str("R5", 0);
        idle(98);
        check("to_early", 32'(frame_err), 32'd0);
        idle(1);
        check("to_err", 32'(frame_err), 32'd1);
        check("to_code", 32'(err_code), 32'd3);
        idle(3);

        // A byte on the would-be timeout cycle wins
        send_str("R5", 0);
        idle(98);
        cycle(1'b1, "6");
        check("to_byte_wins", 32'(frame_err), 32'd0);
        cycle(1'b1, 8'h0D);
        check("to_bin_56", 32'(value_bin), 32'd56);
        check("to_cnt", 32'(frame_count), 32'd4);
        idle(2);

        // Reset mid-frame: partial frame dropped silently
        send_str("R12", 1);
        rst_n = 1'b0;
        cycle(1'b0, 8'h00);
        rst_n = 1'b1;
        check("midrst_err", 32'(frame_err), 32'd0);
        check("midrst_bin", 32'(value_bin), 32'd0);
        check("midrst_cnt", 32'(frame_count), 32'd0);
        frame("R7", 0);
        check("post_rst_bin", 32'(value_bin), 32'd7);

        // Back-to-back strobes
        frame("R8642", 0);
        check("b2b_bin", 32'(value_bin), 32'd8642);
        check("b2b_bcd", 32'(value_bcd), 32'h8642);

        // Randomized mix of good, long, illegal, empty, noise and stalled frames
        for (int f = 0; f < 300; f++) begin
            int kind;
            int gap;
            int n;
            kind = int'($urandom_range(0, 9));
            gap  = int'($urandom_range(0, 2));
            if (kind != 9) send_byte(8'h52, gap);
            case (kind)
                6: begin
                    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + $urandom_range(0, 9)), gap);
                    send_byte(8'h0D, gap);
                end
                7: begin
                    n = int'($urandom_range(0, 2));
                    for (int i = 0; i < n; i++) send_byte(8'(8'h30 + $urandom_range(0, 9)), gap);
                    send_byte(8'(8'h41 + $urandom_range(0, 16)), gap);
                    send_byte(8'h0D, gap);
                end
                8: send_byte(8'h0D, gap);
                9: for (int i = 0; i < 3; i++) send_byte(8'($urandom), gap);
                default: begin
                    n = int'($urandom_range(1, MAXD));
                    for (int i = 0; i < n; i++) send_byte(8'(8'h30 + $urandom_range(0, 9)), gap);
                    if ($urandom_range(0, 19) == 0) idle(TO + 2);
                    send_byte(8'h0D, gap);
                end
            endcase
        end
        idle(TO + 5);

        // Frame counter wrap
        rst_n = 1'b0;
        cycle(1'b0, 8'h00);
        rst_n = 1'b1;
        for (int f = 0; f < 255; f++) frame("R3", 0);
        check("cnt_255", 32'(frame_count), 32'd255);
        frame("R3", 0);
        check("cnt_wrap", 32'(frame_count), 32'd0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sensor_frame_parser.md
Name: sensor_frame_parser

Overview:
Consumes the byte stream from one UART receiver and extracts a sensor reading for the LCD driver, one instance per sensor channel. The sensor frame is ASCII: 'R', 1 to MAX_DIGITS decimal digits, then CR (for example "R123\r"). On each well-formed frame the block publishes the reading as packed BCD (for display) and as binary (for thresholds). It flags malformed frames and stalled frames.

Parameters:
MAX_DIGITS, 4, maximum digits per frame.
BIN_W, 14, binary output width; must be >= ceil(log2(10^MAX_DIGITS)).
TIMEOUT_CYCLES, 1000000, max clk cycles allowed between bytes inside a frame (10 ms at 100 MHz).
START_CHAR, 8'h52, frame start byte ('R').
END_CHAR, 8'h0D, frame terminator (CR).

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous reset, active-low.
rx_data  in  8  byte from the UART receiver; valid only while rx_data_rdy=1.
rx_data_rdy  in  1  one-cycle strobe, one byte per strobe.
value_bcd  out  4*MAX_DIGITS  last good reading, packed BCD, right-justified, leading nibbles 0.
value_bin  out  BIN_W  last good reading, binary.
frame_valid  out  1  one-cycle pulse when value_* update.
frame_err  out  1  one-cycle pulse on a rejected frame.
err_code  out  2  cause of the last error, held: 01 length, 10 illegal char, 11 timeout.
frame_count  out  8  count of good frames, wraps 255->0.

Behaviour:
- Reset (rst_n=0 at a clk edge), synchronous:
  - state=IDLE.
  - value_bcd=0, value_bin=0, frame_valid=0, frame_err=0, err_code=00, frame_count=0.
  - Internal accumulators, digit count and timer are cleared.
  - Reset mid-frame discards the partial frame and issues no error pulse.
- All outputs are registered. frame_valid and frame_err are never high in the same cycle.
- State machine: IDLE, DIGITS.
- IDLE:
  - rx_data_rdy with START_CHAR -> DIGITS; clear bcd_acc, bin_acc, digit count and timer.
  - All other bytes are ignored silently (line noise, partial frames at power-up).
- DIGITS, on rx_data_rdy:
  - Byte '0'..'9' with count<MAX_DIGITS:
    - bcd_acc = {bcd_acc[4*MAX_DIGITS-5:0], byte-8'h30}.
    - bin_acc = bin_acc*10 + (byte-8'h30), computed as (acc<<3)+(acc<<1)+d at BIN_W bits with no overflow possible.
    - count++, timer=0.
  - Digit with count==MAX_DIGITS: error 01, go to IDLE.
  - END_CHAR with count>=1: go to IDLE; in the next cycle value_bcd<=bcd_acc, value_bin<=bin_acc, frame_valid=1, frame_count++. Latency is exactly 1 cycle after the END_CHAR strobe.
  - END_CHAR with count==0: error 01, go to IDLE.
  - START_CHAR: truncated frame. Error 01; stay in DIGITS with accumulators, count and timer cleared (resync onto the new frame).
  - Any other byte: error 10, go to IDLE.
- DIGITS, no strobe:
  - timer++.
  - When timer reaches TIMEOUT_CYCLES-1: error 11, go to IDLE.
  - If a strobe and the timeout coincide in the same cycle, the byte wins and the timeout is not taken.
- Error action: frame_err=1 for the cycle after detection, err_code is updated and held. value_*, frame_valid and frame_count are unchanged (last good reading persists).
- Back-to-back strobes on consecutive cycles are fully supported; no byte is dropped.
- frame_count wraps modulo 256 with no flag.

Test Plan:
- Good frame: reset, then bytes 52,31,32,33,0D at 10-cycle spacing. Expect one frame_valid pulse 1 cycle after the 0D strobe, value_bcd=16'h0123, value_bin=123, frame_count=1, frame_err never high.
- Maximum length and overflow:
  - "R9999\r" gives value_bcd=16'h9999, value_bin=9999.
  - Then "R12345\r": frame_err pulses on the '5' strobe with err_code=01. Values stay 9999. The trailing 0D is ignored in IDLE.
- Illegal and empty frames:
  - "R1A\r" gives frame_err with err_code=10.
  - "R\r" gives err_code=01.
  - In both cases values are unchanged and frame_count is unchanged.
- Resync: "R45R67\r" gives frame_err (01) on the second 52, then frame_valid with value_bin=67, value_bcd=16'h0067.
- Timeout, with TIMEOUT_CYCLES=100:
  - "R5" then silence: frame_err with err_code=11 exactly 99 cycles after the '5' strobe.
  - A new byte strobed on the would-be timeout cycle is accepted instead.
- Reset and wrap:
  - rst_n low for one cycle after "R12": no error pulse, all outputs are 0, and a following "R7\r" yields value_bin=7.
  - 256 good frames return frame_count to 0.
  - Strobes on consecutive clk cycles parse identically to spaced strobes.
